// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp sequencer feeding an 8-bit PWM; duty moves toward a commanded target only on period boundaries.
// Optional interrupt output is enabled by defining PWM_FADE_IRQ_EN.
`timescale 1ns/1ps
module pwm_fade_ctrl #(
  parameter int DUTY_W = 8,
  parameter int PERIOD = 256,
  parameter int STEP   = 1,
  parameter int RATE_W = 8
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              cmd_abort,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              period_end,
  output logic              busy,
  output logic              done
`ifdef PWM_FADE_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RATE_W-1:0] div, rate_lat;
  logic [DUTY_W-1:0] target_lat, next_duty;
  logic [DUTY_W:0]   duty_x, tgt_x, up_x;

  assign period_end = (cnt == LAST);

  // One extra bit keeps the sum/compare from wrapping, so the step clamps at the target.
  always_comb begin
    duty_x    = {1'b0, duty_cycle};
    tgt_x     = {1'b0, target_lat};
    up_x      = duty_x + STEP_X;
    next_duty = target_lat;
    if (duty_x < tgt_x) begin
      if (up_x < tgt_x) next_duty = up_x[DUTY_W-1:0];
    end else if (duty_x > tgt_x) begin
      if (duty_x >= tgt_x + STEP_X) next_duty = duty_cycle - STEP_D;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= '0;
      rate_lat   <= '0;
      target_lat <= '0;
      duty_cycle <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt  <= period_end ? '0 : cnt + 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target_lat <= cmd_target;
            rate_lat   <= cmd_rate;
            div        <= '0;
            if (cmd_target != duty_cycle) begin
              state     <= RAMP;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RAMP: begin
          // Abort takes priority over both completion and a due step.
          if (cmd_abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            div       <= '0;
          end else if (duty_cycle == target_lat) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (period_end) begin
            if (div == rate_lat) begin
              div        <= '0;
              duty_cycle <= next_duty;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_FADE_IRQ_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)     irq <= 1'b0;
    else if (irq_clr) irq <= 1'b0;
    else if (done)    irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: stimulus queues expected duty/done events, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_pwm_fade_ctrl;
  typedef struct {bit is_done; int value; int gap;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, rst3_n = 1'b0;
  logic v0 = 0, a0 = 0, rdy0, pe0, busy0, done0;
  logic v3 = 0, a3 = 0, rdy3, pe3, busy3, done3;
  logic [7:0] tgt0 = 0, rate0 = 0, duty0, tgt3 = 0, rate3 = 0, duty3;
`ifdef PWM_FADE_IRQ_EN
  logic irq0, irq3, irq_clr0 = 0, irq_clr3 = 0;
`endif

  int checks = 0, errors = 0;
  exp_t q0[$], q3[$];

  pwm_fade_ctrl dut0 (
    .clock_in(clk), .reset_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_target(tgt0), .cmd_rate(rate0), .cmd_abort(a0), .duty_cycle(duty0),
    .period_end(pe0), .busy(busy0), .done(done0)
`ifdef PWM_FADE_IRQ_EN
    , .irq(irq0), .irq_clr(irq_clr0)
`endif
  );

  pwm_fade_ctrl #(.PERIOD(16), .STEP(3)) dut3 (
    .clock_in(clk), .reset_n(rst3_n), .cmd_valid(v3), .cmd_ready(rdy3),
    .cmd_target(tgt3), .cmd_rate(rate3), .cmd_abort(a3), .duty_cycle(duty3),
    .period_end(pe3), .busy(busy3), .done(done3)
`ifdef PWM_FADE_IRQ_EN
    , .irq(irq3), .irq_clr(irq_clr3)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_event(input string nm, input exp_t e, input bit is_done,
                             input int val, input int gap, input bit pe_ok);
    chk({nm, " kind"}, is_done, e.is_done);
    chk({nm, " value"}, val, e.value);
    if (e.gap != 0) chk({nm, " gap"}, gap, e.gap);
    if (!is_done) chk({nm, " on period boundary"}, pe_ok, 1);
  endtask

  function automatic exp_t mk(input bit d, input int v, input int g);
    exp_t e;
    e.is_done = d; e.value = v; e.gap = g;
    return e;
  endfunction

  // Monitors: every duty change and every done pulse consumes one expected entry.
  int cyc0, cyc3;
  logic [7:0] last0, last3;
  bit pe_prev0, pe_prev3;
  exp_t e0, e3;

  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = 0; cyc0 = 0; pe_prev0 = 0;
    end else begin
      cyc0++;
      if (duty0 !== last0) begin
        if (q0.size() == 0) chk("dut0 unexpected duty change", duty0, last0);
        else begin e0 = q0.pop_front(); check_event("dut0 duty", e0, 0, duty0, cyc0, pe_prev0); end
        cyc0 = 0; last0 = duty0;
      end
      if (done0) begin
        if (q0.size() == 0) chk("dut0 unexpected done", done0, 0);
        else begin e0 = q0.pop_front(); check_event("dut0 done", e0, 1, duty0, cyc0, pe_prev0); end
      end
      pe_prev0 = pe0;
    end
  end

  always @(negedge clk) begin
    if (!rst3_n) begin
      last3 = 0; cyc3 = 0; pe_prev3 = 0;
    end else begin
      cyc3++;
      if (duty3 !== last3) begin
        if (q3.size() == 0) chk("dut3 unexpected duty change", duty3, last3);
        else begin e3 = q3.pop_front(); check_event("dut3 duty", e3, 0, duty3, cyc3, pe_prev3); end
        cyc3 = 0; last3 = duty3;
      end
      if (done3) begin
        if (q3.size() == 0) chk("dut3 unexpected done", done3, 0);
        else begin e3 = q3.pop_front(); check_event("dut3 done", e3, 1, duty3, cyc3, pe_prev3); end
      end
      pe_prev3 = pe3;
    end
  end

  task automatic send0(input int t, input int r);
    for (int i = 0; i < 5000 && !rdy0; i++) begin @(posedge clk); #1; end
    chk("dut0 ready before send", rdy0, 1);
    v0 = 1; tgt0 = 8'(t); rate0 = 8'(r);
    @(posedge clk); #1;
    v0 = 0;
  endtask

  task automatic send3(input int t, input int r);
    for (int i = 0; i < 5000 && !rdy3; i++) begin @(posedge clk); #1; end
    chk("dut3 ready before send", rdy3, 1);
    v3 = 1; tgt3 = 8'(t); rate3 = 8'(r);
    @(posedge clk); #1;
    v3 = 0;
  endtask

  task automatic drain0(input int lim);
    for (int i = 0; i < lim && q0.size() != 0; i++) @(posedge clk);
    #1 chk("dut0 scoreboard drained", q0.size(), 0);
  endtask

  task automatic drain3(input int lim);
    for (int i = 0; i < lim && q3.size() != 0; i++) @(posedge clk);
    #1 chk("dut3 scoreboard drained", q3.size(), 0);
  endtask

  task automatic wait_duty0(input int d, input int lim);
    for (int i = 0; i < lim && duty0 != d; i++) begin @(posedge clk); #1; end
    chk("dut0 reached duty", duty0, d);
  endtask

  task automatic pe_distance(input string nm, input int expd);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!pe0 && n < 1000);
    chk(nm, n, expd);
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("reset duty", duty0, 0);
    chk("reset cmd_ready", rdy0, 1);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset period_end", pe0, 0);
    rst_n = 1; rst3_n = 1;
    pe_distance("first period_end after reset", 255);
    pe_distance("period_end spacing", 256);
    chk("idle duty", duty0, 0);

    // 0 -> 4 at rate 0; a command offered while busy must be dropped
    q0.push_back(mk(0, 1, 0));
    q0.push_back(mk(0, 2, 256));
    q0.push_back(mk(0, 3, 256));
    q0.push_back(mk(0, 4, 256));
    q0.push_back(mk(1, 4, 1));
    send0(4, 0);
    chk("ramp busy", busy0, 1);
    chk("ramp cmd_ready", rdy0, 0);
    v0 = 1; tgt0 = 100;
    repeat (20) begin @(posedge clk); #1; end
    v0 = 0;
    drain0(2000);
    @(posedge clk); #1;
    chk("after ramp cmd_ready", rdy0, 1);
    chk("after ramp busy", busy0, 0);
    chk("after ramp duty", duty0, 4);

    // Abort on the period_end cycle that would step 10 -> 11
    q0.push_back(mk(0, 5, 0));
    for (int v = 6; v <= 10; v++) q0.push_back(mk(0, v, 256));
    send0(200, 0);
    wait_duty0(10, 4000);
    for (int i = 0; i < 300 && !pe0; i++) begin @(posedge clk); #1; end
    chk("abort aligned to period_end", pe0, 1);
    a0 = 1;
    @(posedge clk); #1;
    a0 = 0;
    chk("abort busy", busy0, 0);
    chk("abort cmd_ready", rdy0, 1);
    chk("abort duty frozen", duty0, 10);
    repeat (600) begin @(posedge clk); #1; end
    chk("duty still frozen", duty0, 10);
    q0.push_back(mk(1, 10, 0));
    send0(10, 5);
    drain0(10);
    chk("same-target duty", duty0, 10);

    // Asynchronous reset mid-ramp at duty 37
    q0.push_back(mk(0, 11, 0));
    for (int v = 12; v <= 37; v++) q0.push_back(mk(0, v, 256));
    send0(200, 0);
    wait_duty0(37, 30 * 256);
    repeat (50) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async reset duty", duty0, 0);
    chk("async reset busy", busy0, 0);
    chk("async reset cmd_ready", rdy0, 1);
    chk("async reset period_end", pe0, 0);
    chk("nothing pending at reset", q0.size(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    pe_distance("period_end after mid-ramp reset", 255);

    // STEP=3, PERIOD=16 instance: clamp high, rate 1, then clamp low
    d = 0;
    while (d < 250) begin
      q3.push_back(mk(0, (d + 3 > 250) ? 250 : d + 3, (d == 0) ? 0 : 16));
      d = (d + 3 > 250) ? 250 : d + 3;
    end
    q3.push_back(mk(1, 250, 1));
    send3(250, 0);
    drain3(2000);
    q3.push_back(mk(0, 253, 0));
    q3.push_back(mk(0, 255, 32));
    q3.push_back(mk(1, 255, 1));
    send3(255, 1);
    drain3(200);
    d = 255;
    while (d > 1) begin
      q3.push_back(mk(0, (d - 3 < 1) ? 1 : d - 3, (d == 255) ? 0 : 16));
      d = (d - 3 < 1) ? 1 : d - 3;
    end
    q3.push_back(mk(1, 1, 1));
    send3(1, 0);
    drain3(2000);
    chk("dut3 clamped low", duty3, 1);

    // Abort together with a valid command in IDLE: command wins
    q0.push_back(mk(0, 1, 0));
    q0.push_back(mk(0, 2, 256));
    q0.push_back(mk(1, 2, 1));
    a0 = 1;
    send0(2, 0);
    a0 = 0;
    chk("abort+valid accepted", busy0, 1);
`ifdef PWM_FADE_IRQ_EN
    for (int i = 0; i < 1000 && !irq0; i++) begin @(posedge clk); #1; end
    chk("irq set after done", irq0, 1);
    repeat (100) begin @(posedge clk); #1; end
    chk("irq holds", irq0, 1);
    q0.push_back(mk(0, 3, 0));
    q0.push_back(mk(1, 3, 1));
    send0(3, 0);
    for (int i = 0; i < 600 && !done0; i++) begin @(posedge clk); #1; end
    chk("second done seen", done0, 1);
    irq_clr0 = 1;
    @(posedge clk); #1;
    irq_clr0 = 0;
    chk("irq clear wins over done", irq0, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("irq stays clear", irq0, 0);
`endif
    drain0(1000);
    repeat (5) @(posedge clk);
    #1;
    chk("final dut0 queue", q0.size(), 0);
    chk("final dut3 queue", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global timeout: got 1 expected 0");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
